multicycle_sequencer: RTL and testbench
=======================================

MULTICYCLE_SEQUENCER -- requirements
Module: multicycle_sequencer

Interface
REQ-001 SHALL have parameter XLEN, default 32, datapath and address width.
REQ-002 SHALL have parameter RESET_PC, default 32'h0, PC value after reset.
REQ-003 SHALL have parameter MEM_TIMEOUT, default 16, maximum wait cycles for a memory response.
REQ-004 SHALL have port clk  in  1  sole clock; all state changes on its rising edge.
REQ-005 SHALL have port rst  in  1  reset, synchronous and active-high.
REQ-006 SHALL have port run  in  1  level; leaves IDLE when high.
REQ-007 SHALL have port step_mode  in  1  high: pause in IDLE after each retired instruction.
REQ-008 SHALL have ports mem_req/mem_we  out  1/1  and mem_addr  out  XLEN  (memory request, write flag, address).
REQ-009 SHALL have ports mem_ready/mem_err  in  1/1  (response handshake and bus error).
REQ-010 SHALL have port mem_rdata  in  XLEN  (read data).
REQ-011 SHALL have ports is_load/is_store/is_halt/decode_error  in  1  each, from the decoder.
REQ-012 SHALL have ports ea  in  XLEN  (effective address) and next_pc  in  XLEN.
REQ-013 SHALL have ports pc/instr  out  XLEN, reg_we  out  1, state  out  4, trap_cause  out  3.

Function
REQ-014 SHALL use states IDLE, FETCH, WAIT_FETCH, DECODE, EXECUTE, MEM, WAIT_MEM, WRITEBACK, HALT, TRAP.
REQ-015 IDLE->FETCH SHALL occur when run=1; otherwise the FSM holds IDLE.
REQ-016 FETCH SHALL assert mem_req=1, mem_we=0, mem_addr=pc for exactly one cycle, then go to WAIT_FETCH.
REQ-017 WAIT_FETCH SHALL hold until mem_ready=1, latch instr<=mem_rdata in that cycle, then go to DECODE.
REQ-018 DECODE->EXECUTE SHALL take one cycle; in EXECUTE, is_halt->HALT, decode_error->TRAP(cause 1), is_load|is_store->MEM, else->WRITEBACK.
REQ-019 MEM SHALL issue one mem_req cycle with mem_addr=ea and mem_we=is_store, then go to WAIT_MEM.
REQ-020 WAIT_MEM SHALL hold until mem_ready=1, then go to WRITEBACK.
REQ-021 mem_err=1 together with mem_ready=1 SHALL go to TRAP with cause 2 (fetch) or 3 (data), and SHALL NOT latch instr.
REQ-022 ea[1:0]!=0 in EXECUTE for a word access SHALL go to TRAP(cause 4) without issuing mem_req.
REQ-023 WRITEBACK SHALL pulse reg_we for one cycle unless is_store, latch pc<=next_pc, then go to IDLE if step_mode=1, else FETCH.
REQ-024 HALT and TRAP SHALL be absorbing until reset; trap_cause SHALL hold its value; pc SHALL hold the faulting instruction address.
REQ-025 mem_req SHALL never be high for two consecutive cycles; mem_ready outside a wait state SHALL be ignored.
REQ-026 Minimum latency SHALL be 5 cycles (ALU op, zero-wait memory) and 7 cycles (load/store).
REQ-027 Any undefined state encoding SHALL go to TRAP with cause 7.

Reset
REQ-028 rst=1 at a clock edge SHALL force state=IDLE, pc=RESET_PC, instr=0, mem_req=0, mem_we=0, mem_addr=0, reg_we=0, trap_cause=0, overriding every other input, including mid-transaction.

Configuration
REQ-029 With macro SEQ_MEM_TIMEOUT_EN defined, a counter SHALL count cycles spent in WAIT_FETCH/WAIT_MEM; reaching MEM_TIMEOUT SHALL go to TRAP with cause 5; the counter SHALL clear on each state entry.
REQ-030 Without SEQ_MEM_TIMEOUT_EN, the wait states SHALL wait indefinitely, cause 5 SHALL never be produced, and no counter logic SHALL be synthesised.

Structure
REQ-031 Package seq_pkg SHALL hold the state encoding enum (IDLE=0 ... TRAP=9) and the trap_cause constants (NONE=0, DECODE=1, FETCH_ERR=2, DATA_ERR=3, MISALIGN=4, TIMEOUT=5, BAD_STATE=7).
REQ-032 The timeout counter SHALL be sub-module seq_watchdog, instantiated only under SEQ_MEM_TIMEOUT_EN.

Verification
REQ-033 Reset, run=1, memory ready one cycle after each request, ALU instruction at 0x0 with next_pc=4 -> one reg_we pulse, pc=4, 5 cycles from FETCH to the next FETCH.
REQ-034 Load with ea=0x100 and mem_ready delayed 3 cycles -> mem_addr=0x100 with mem_we=0, reg_we once, 10 cycles in total.
REQ-035 Store with ea=0x102 -> TRAP, trap_cause=4, no data mem_req, pc unchanged.
REQ-036 mem_err=1 on fetch at pc=0x8 -> TRAP, trap_cause=2, instr unchanged, pc=0x8.
REQ-037 With SEQ_MEM_TIMEOUT_EN and MEM_TIMEOUT=16, mem_ready held low -> TRAP, cause 5, on the 16th wait cycle; without the macro -> remains in WAIT_FETCH for 1000 cycles.
REQ-038 step_mode=1, run pulsed -> exactly one instruction retired, then IDLE; rst asserted in WAIT_MEM -> IDLE and pc=RESET_PC on the next cycle.

Source files
------------

// File: rtl/seq_pkg.sv
// Shared state encoding and trap cause codes for the multi-cycle sequencer.
package seq_pkg;

    typedef enum logic [3:0] {
        IDLE       = 4'd0,
        FETCH      = 4'd1,
        WAIT_FETCH = 4'd2,
        DECODE     = 4'd3,
        EXECUTE    = 4'd4,
        MEM        = 4'd5,
        WAIT_MEM   = 4'd6,
        WRITEBACK  = 4'd7,
        HALT       = 4'd8,
        TRAP       = 4'd9
    } seq_state_e;

    localparam logic [2:0] CAUSE_NONE      = 3'd0;
    localparam logic [2:0] CAUSE_DECODE    = 3'd1;
    localparam logic [2:0] CAUSE_FETCH_ERR = 3'd2;
    localparam logic [2:0] CAUSE_DATA_ERR  = 3'd3;
    localparam logic [2:0] CAUSE_MISALIGN  = 3'd4;
    localparam logic [2:0] CAUSE_TIMEOUT   = 3'd5;
    localparam logic [2:0] CAUSE_BAD_STATE = 3'd7;

    function automatic logic is_wait_state(input seq_state_e s);
        return (s == WAIT_FETCH) || (s == WAIT_MEM);
    endfunction

endpackage

// File: rtl/seq_watchdog.sv
// Wait-state cycle counter; flags the cycle in which the MEM_TIMEOUT-th wait cycle is reached.
module seq_watchdog #(
    parameter int MEM_TIMEOUT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic waiting_i,
    input  logic restart_i,
    output logic expired_o
);
    localparam int CNT_W = $clog2(MEM_TIMEOUT + 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    // cnt_q holds the number of wait cycles already completed in the current state
    always_comb begin
        cnt_d = '0;
        if (waiting_i && !restart_i) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    assign expired_o = waiting_i && (cnt_q == CNT_W'(MEM_TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/multicycle_sequencer.sv
// Multi-cycle fetch/decode/execute/memory/writeback control FSM.
// Defining SEQ_MEM_TIMEOUT_EN adds a wait-state watchdog (trap cause 5).
module multicycle_sequencer
    import seq_pkg::*;
#(
    parameter int              XLEN        = 32,
    parameter logic [XLEN-1:0] RESET_PC    = '0,
    parameter int              MEM_TIMEOUT = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            run,
    input  logic            step_mode,
    output logic            mem_req,
    output logic            mem_we,
    output logic [XLEN-1:0] mem_addr,
    input  logic            mem_ready,
    input  logic            mem_err,
    input  logic [XLEN-1:0] mem_rdata,
    input  logic            is_load,
    input  logic            is_store,
    input  logic            is_halt,
    input  logic            decode_error,
    input  logic [XLEN-1:0] ea,
    input  logic [XLEN-1:0] next_pc,
    output logic [XLEN-1:0] pc,
    output logic [XLEN-1:0] instr,
    output logic            reg_we,
    output logic [3:0]      state,
    output logic [2:0]      trap_cause
);
    seq_state_e      state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] instr_q, instr_d;
    logic [2:0]      cause_q, cause_d;
    logic            wait_expired;
    logic            misaligned;

    assign misaligned = (ea[1:0] != 2'b00);

`ifdef SEQ_MEM_TIMEOUT_EN
    seq_watchdog #(
        .MEM_TIMEOUT(MEM_TIMEOUT)
    ) u_watchdog (
        .clk      (clk),
        .rst      (rst),
        .waiting_i(is_wait_state(state_q)),
        .restart_i(state_d != state_q),
        .expired_o(wait_expired)
    );
`else
    assign wait_expired = 1'b0;
`endif

    // Memory strobes are decoded from the current state, so a request lasts exactly one cycle
    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        instr_d  = instr_q;
        cause_d  = cause_q;
        mem_req  = 1'b0;
        mem_we   = 1'b0;
        mem_addr = '0;
        reg_we   = 1'b0;
        case (state_q)
            IDLE: begin
                if (run) state_d = FETCH;
            end
            FETCH: begin
                mem_req  = 1'b1;
                mem_addr = pc_q;
                state_d  = WAIT_FETCH;
            end
            WAIT_FETCH: begin
                if (mem_ready) begin
                    if (mem_err) begin
                        state_d = TRAP;
                        cause_d = CAUSE_FETCH_ERR;
                    end else begin
                        instr_d = mem_rdata;
                        state_d = DECODE;
                    end
                end else if (wait_expired) begin
                    state_d = TRAP;
                    cause_d = CAUSE_TIMEOUT;
                end
            end
            DECODE: begin
                state_d = EXECUTE;
            end
            EXECUTE: begin
                if (is_halt) begin
                    state_d = HALT;
                end else if (decode_error) begin
                    state_d = TRAP;
                    cause_d = CAUSE_DECODE;
                end else if (is_load || is_store) begin
                    if (misaligned) begin
                        state_d = TRAP;
                        cause_d = CAUSE_MISALIGN;
                    end else begin
                        state_d = MEM;
                    end
                end else begin
                    state_d = WRITEBACK;
                end
            end
            MEM: begin
                mem_req  = 1'b1;
                mem_we   = is_store;
                mem_addr = ea;
                state_d  = WAIT_MEM;
            end
            WAIT_MEM: begin
                if (mem_ready) begin
                    if (mem_err) begin
                        state_d = TRAP;
                        cause_d = CAUSE_DATA_ERR;
                    end else begin
                        state_d = WRITEBACK;
                    end
                end else if (wait_expired) begin
                    state_d = TRAP;
                    cause_d = CAUSE_TIMEOUT;
                end
            end
            WRITEBACK: begin
                reg_we  = !is_store;
                pc_d    = next_pc;
                state_d = step_mode ? IDLE : FETCH;
            end
            HALT, TRAP: begin
                state_d = state_q;
            end
            default: begin
                state_d = TRAP;
                cause_d = CAUSE_BAD_STATE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            pc_q    <= RESET_PC;
            instr_q <= '0;
            cause_q <= CAUSE_NONE;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
            cause_q <= cause_d;
        end
    end

    assign state      = state_q;
    assign pc         = pc_q;
    assign instr      = instr_q;
    assign trap_cause = cause_q;

endmodule

// File: tb/tb_multicycle_sequencer.sv
// Bench for multicycle_sequencer: directed table, hand sequences and randomized instructions vs a timing model.
`timescale 1ns/1ps
module tb_multicycle_sequencer;

    localparam logic [3:0] ST_IDLE       = 4'd0;
    localparam logic [3:0] ST_FETCH      = 4'd1;
    localparam logic [3:0] ST_WAIT_FETCH = 4'd2;
    localparam logic [3:0] ST_WAIT_MEM   = 4'd6;
    localparam logic [3:0] ST_HALT       = 4'd8;
    localparam logic [3:0] ST_TRAP       = 4'd9;

    logic        clk = 1'b0;
    logic        rst, run, step_mode;
    logic        mem_req, mem_we, mem_ready, mem_err;
    logic [31:0] mem_addr, mem_rdata, ea, next_pc, pc, instr;
    logic        is_load, is_store, is_halt, decode_error, reg_we;
    logic [3:0]  state;
    logic [2:0]  trap_cause;

    always #5 clk = ~clk;

    multicycle_sequencer dut (
        .clk(clk), .rst(rst), .run(run), .step_mode(step_mode),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_ready(mem_ready), .mem_err(mem_err), .mem_rdata(mem_rdata),
        .is_load(is_load), .is_store(is_store), .is_halt(is_halt), .decode_error(decode_error),
        .ea(ea), .next_pc(next_pc), .pc(pc), .instr(instr), .reg_we(reg_we),
        .state(state), .trap_cause(trap_cause)
    );

    typedef struct packed {
        logic        ld, st, halt, derr, ferr, dmerr;
        int          fdly, ddly;
        logic [31:0] ea, npc, word;
    } in_t;

    typedef struct packed {
        logic [3:0]  st;
        logic [2:0]  cause;
        int          cycles, regwe, dreqs, b2b;
        logic [31:0] daddr, faddr, pc, instr;
        logic        dwe, fwe;
    } res_t;

    typedef struct packed {
        in_t  in;
        logic step;
        res_t exp;
    } vec_t;

    int checks = 0;
    int failures = 0;
    bit noise_en = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic in_t mk_in(input bit ld, st, halt, derr, ferr, dmerr,
                                  input int fdly, ddly, input logic [31:0] ea_v, npc, word);
        in_t r;
        r.ld = ld; r.st = st; r.halt = halt; r.derr = derr; r.ferr = ferr; r.dmerr = dmerr;
        r.fdly = fdly; r.ddly = ddly; r.ea = ea_v; r.npc = npc; r.word = word;
        return r;
    endfunction

    // Expected outcome of one instruction starting at its FETCH cycle (t=0)
    function automatic res_t model(input in_t in, input logic [31:0] pc0, input logic [31:0] instr0,
                                   input bit step);
        res_t r;
        r = '0;
        r.faddr = pc0;
        r.pc    = pc0;
        r.instr = instr0;
        if (in.ferr) begin
            r.st = ST_TRAP; r.cause = 3'd2; r.cycles = 2 + in.fdly;
            return r;
        end
        r.instr = in.word;
        if (in.halt) begin
            r.st = ST_HALT; r.cycles = 4 + in.fdly;
        end else if (in.derr) begin
            r.st = ST_TRAP; r.cause = 3'd1; r.cycles = 4 + in.fdly;
        end else if ((in.ld || in.st) && in.ea[1:0] != 2'b00) begin
            r.st = ST_TRAP; r.cause = 3'd4; r.cycles = 4 + in.fdly;
        end else if (in.ld || in.st) begin
            r.dreqs = 1; r.daddr = in.ea; r.dwe = in.st;
            if (in.dmerr) begin
                r.st = ST_TRAP; r.cause = 3'd3; r.cycles = 6 + in.fdly + in.ddly;
            end else begin
                r.regwe = in.st ? 0 : 1; r.pc = in.npc;
                r.st = step ? ST_IDLE : ST_FETCH; r.cycles = 7 + in.fdly + in.ddly;
            end
        end else begin
            r.regwe = 1; r.pc = in.npc;
            r.st = step ? ST_IDLE : ST_FETCH; r.cycles = 5 + in.fdly;
        end
        return r;
    endfunction

    task automatic do_reset();
        rst = 1'b1; run = 1'b0; mem_ready = 1'b0; mem_err = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    // Acts as decoder and memory for one instruction; called and returns at posedge+1
    task automatic exec(input in_t in, output res_t r);
        int  t = 0;
        int  cnt = 0;
        int  nreq = 0;
        bit  pend = 0, fph = 0, prev = 0, started = 0, done = 0;
        r = '0;
        is_load = in.ld; is_store = in.st; is_halt = in.halt; decode_error = in.derr;
        ea = in.ea; next_pc = in.npc;
        for (int c = 0; c < 400 && !done; c++) begin
            if (c > 0) begin
                @(posedge clk);
                #1;
            end
            mem_ready = 1'b0; mem_err = 1'b0;
            if (!started && state == ST_FETCH) begin
                started = 1;
            end else if (started) begin
                t++;
                if (state == ST_FETCH || state == ST_IDLE || state == ST_HALT || state == ST_TRAP) begin
                    done = 1;
                    r.st = state; r.cause = trap_cause; r.pc = pc; r.instr = instr; r.cycles = t;
                end
            end
            if (started && !done) begin
                if (reg_we) r.regwe++;
                if (mem_req) begin
                    if (prev) r.b2b++;
                    if (nreq == 0) begin
                        r.faddr = mem_addr; r.fwe = mem_we;
                    end else begin
                        r.dreqs++; r.daddr = mem_addr; r.dwe = mem_we;
                    end
                    pend = 1; fph = (nreq == 0); cnt = fph ? in.fdly : in.ddly; nreq++;
                end else if (pend) begin
                    if (cnt == 0) begin
                        mem_ready = 1'b1;
                        mem_err   = fph ? in.ferr : in.dmerr;
                        mem_rdata = fph ? in.word : $urandom;
                        pend = 0;
                    end else begin
                        cnt--;
                    end
                end else if (noise_en) begin
                    mem_ready = 1'($urandom_range(0, 1));
                    mem_err   = 1'($urandom_range(0, 1));
                    mem_rdata = $urandom;
                end
                prev = mem_req;
            end
        end
        if (!done) begin
            checks++; failures++;
            $display("FAIL exec_timeout: got no end state, state=%0d", state);
            r.cycles = 9999;
        end
    endtask

    task automatic cmp_res(input string tag, input res_t a, input res_t e);
        check({tag, ".state"},  a.st,     e.st);
        check({tag, ".cause"},  a.cause,  e.cause);
        check({tag, ".cycles"}, a.cycles, e.cycles);
        check({tag, ".reg_we"}, a.regwe,  e.regwe);
        check({tag, ".dreqs"},  a.dreqs,  e.dreqs);
        check({tag, ".daddr"},  a.daddr,  e.daddr);
        check({tag, ".dwe"},    a.dwe,    e.dwe);
        check({tag, ".faddr"},  a.faddr,  e.faddr);
        check({tag, ".fwe"},    a.fwe,    1'b0);
        check({tag, ".pc"},     a.pc,     e.pc);
        check({tag, ".instr"},  a.instr,  e.instr);
        check({tag, ".b2b_req"}, a.b2b,   0);
    endtask

    function automatic vec_t mk_vec(input in_t in, input bit step, input logic [3:0] st, input logic [2:0] cause,
                                    input int cyc, regwe, dreqs, input logic [31:0] daddr,
                                    input bit dwe, input logic [31:0] epc, einstr);
        vec_t v;
        v.in = in; v.step = step; v.exp = '0;
        v.exp.st = st; v.exp.cause = cause; v.exp.cycles = cyc; v.exp.regwe = regwe;
        v.exp.dreqs = dreqs; v.exp.daddr = daddr; v.exp.dwe = dwe; v.exp.faddr = 32'h0;
        v.exp.pc = epc; v.exp.instr = einstr;
        return v;
    endfunction

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish, state=%0d", state);
        $fatal(1, "global timeout");
    end

    initial begin
        vec_t        tbl[$];
        res_t        r, e;
        logic [31:0] pc_m, instr_m;
        int          bad;
        in_t         ri;

        // Each vector starts from reset (pc=0, instr=0), step_mode as given
        //                    ld st hl de fe me fd dd  ea          npc         word
        tbl.push_back(mk_vec(mk_in(0,0,0,0,0,0, 0, 0, 32'h0,      32'h4,      32'h13), 0, ST_FETCH, 3'd0,  5, 1, 0, 32'h0,   0, 32'h4,  32'h13));
        tbl.push_back(mk_vec(mk_in(1,0,0,0,0,0, 0, 3, 32'h100,    32'h4,      32'h03), 0, ST_FETCH, 3'd0, 10, 1, 1, 32'h100, 0, 32'h4,  32'h03));
        tbl.push_back(mk_vec(mk_in(0,1,0,0,0,0, 0, 0, 32'h102,    32'h4,      32'h23), 0, ST_TRAP,  3'd4,  4, 0, 0, 32'h0,   0, 32'h0,  32'h23));
        tbl.push_back(mk_vec(mk_in(0,1,0,0,0,0, 2, 1, 32'h200,    32'h8,      32'h23), 0, ST_FETCH, 3'd0, 10, 0, 1, 32'h200, 1, 32'h8,  32'h23));
        tbl.push_back(mk_vec(mk_in(0,0,1,0,0,0, 0, 0, 32'h0,      32'h4,      32'h73), 0, ST_HALT,  3'd0,  4, 0, 0, 32'h0,   0, 32'h0,  32'h73));
        tbl.push_back(mk_vec(mk_in(0,0,0,1,0,0, 0, 0, 32'h0,      32'h4,      32'hFF), 0, ST_TRAP,  3'd1,  4, 0, 0, 32'h0,   0, 32'h0,  32'hFF));
        tbl.push_back(mk_vec(mk_in(0,0,0,0,1,0, 1, 0, 32'h0,      32'h4,      32'hAA), 0, ST_TRAP,  3'd2,  3, 0, 0, 32'h0,   0, 32'h0,  32'h0));
        tbl.push_back(mk_vec(mk_in(1,0,0,0,0,1, 0, 0, 32'h10,     32'h4,      32'h03), 0, ST_TRAP,  3'd3,  6, 0, 1, 32'h10,  0, 32'h0,  32'h03));
        tbl.push_back(mk_vec(mk_in(0,0,0,0,0,0, 3, 0, 32'h0,      32'h40,     32'h33), 1, ST_IDLE,  3'd0,  8, 1, 0, 32'h0,   0, 32'h40, 32'h33));
        tbl.push_back(mk_vec(mk_in(1,0,0,0,0,0, 0, 0, 32'h101,    32'h4,      32'h03), 0, ST_TRAP,  3'd4,  4, 0, 0, 32'h0,   0, 32'h0,  32'h03));
        tbl.push_back(mk_vec(mk_in(0,0,1,1,0,0, 0, 0, 32'h0,      32'h4,      32'h77), 0, ST_HALT,  3'd0,  4, 0, 0, 32'h0,   0, 32'h0,  32'h77));

        step_mode = 1'b0; is_load = 0; is_store = 0; is_halt = 0; decode_error = 0;
        ea = '0; next_pc = '0; mem_rdata = '0;
        do_reset();

        check("reset.state", state, ST_IDLE);
        check("reset.pc", pc, 32'h0);
        check("reset.mem_req", mem_req, 1'b0);
        check("reset.mem_addr", mem_addr, 32'h0);
        repeat (3) @(posedge clk);
        #1;
        check("idle_hold.state", state, ST_IDLE);

        foreach (tbl[i]) begin
            do_reset();
            step_mode = tbl[i].step;
            run = 1'b1;
            exec(tbl[i].in, r);
            cmp_res($sformatf("vec%0d", i), r, tbl[i].exp);
        end
        step_mode = 1'b0;

        // Fetch error at pc=0x8 after two retired instructions, then absorbing TRAP
        do_reset();
        run = 1'b1;
        exec(mk_in(0,0,0,0,0,0, 0, 0, 32'h0, 32'h4, 32'h11), r);
        cmp_res("seq1.i0", r, model(mk_in(0,0,0,0,0,0, 0, 0, 32'h0, 32'h4, 32'h11), 32'h0, 32'h0, 0));
        exec(mk_in(0,0,0,0,0,0, 1, 0, 32'h0, 32'h8, 32'h22), r);
        cmp_res("seq1.i1", r, model(mk_in(0,0,0,0,0,0, 1, 0, 32'h0, 32'h8, 32'h22), 32'h4, 32'h11, 0));
        exec(mk_in(0,0,0,0,1,0, 0, 0, 32'h0, 32'hC, 32'h33), r);
        check("ferr.state", r.st, ST_TRAP);
        check("ferr.cause", r.cause, 3'd2);
        check("ferr.pc", r.pc, 32'h8);
        check("ferr.instr", r.instr, 32'h22);
        bad = 0;
        for (int c = 0; c < 20; c++) begin
            mem_ready = 1'($urandom_range(0, 1)); mem_err = 1'($urandom_range(0, 1));
            is_load = 1'($urandom_range(0, 1)); is_halt = 1'($urandom_range(0, 1));
            @(posedge clk);
            #1;
            if (state !== ST_TRAP || trap_cause !== 3'd2 || pc !== 32'h8 || mem_req !== 1'b0) bad++;
        end
        check("trap_absorbing", bad, 0);

        do_reset();
        check("reset_after_trap.state", state, ST_IDLE);
        check("reset_after_trap.pc", pc, 32'h0);
        check("reset_after_trap.instr", instr, 32'h0);
        check("reset_after_trap.cause", trap_cause, 3'd0);
        check("reset_after_trap.mem_we", mem_we, 1'b0);
        check("reset_after_trap.reg_we", reg_we, 1'b0);

        // Single step: run pulsed for one cycle retires exactly one instruction
        step_mode = 1'b1;
        run = 1'b1;
        @(posedge clk);
        #1;
        run = 1'b0;
        exec(mk_in(0,0,0,0,0,0, 0, 0, 32'h0, 32'h4, 32'h44), r);
        cmp_res("step", r, model(mk_in(0,0,0,0,0,0, 0, 0, 32'h0, 32'h4, 32'h44), 32'h0, 32'h0, 1));
        bad = 0;
        for (int c = 0; c < 10; c++) begin
            @(posedge clk);
            #1;
            if (state !== ST_IDLE || reg_we !== 1'b0 || mem_req !== 1'b0) bad++;
        end
        check("step_stays_idle", bad, 0);
        step_mode = 1'b0;

        // Reset while waiting on a data access
        do_reset();
        run = 1'b1;
        exec(mk_in(0,0,0,0,0,0, 0, 0, 32'h0, 32'h4, 32'h55), r);
        check("midreset.pc_before", r.pc, 32'h4);
        is_load = 1'b1; is_store = 0; is_halt = 0; decode_error = 0; ea = 32'h40; mem_rdata = 32'h3;
        for (int c = 0; c < 30; c++) begin
            @(posedge clk);
            #1;
            if (state == ST_WAIT_MEM) break;
            mem_ready = (state == ST_WAIT_FETCH);
        end
        mem_ready = 1'b0;
        check("midreset.in_wait_mem", state, ST_WAIT_MEM);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("midreset.state", state, ST_IDLE);
        check("midreset.pc", pc, 32'h0);
        check("midreset.instr", instr, 32'h0);
        check("midreset.mem_req", mem_req, 1'b0);

        // Memory never answers a fetch
        do_reset();
        is_load = 0; mem_ready = 1'b0;
        run = 1'b1;
        @(posedge clk);
        #1;
        check("noresp.fetch", state, ST_FETCH);
`ifdef SEQ_MEM_TIMEOUT_EN
        bad = 0;
        for (int c = 0; c < 100; c++) begin
            @(posedge clk);
            #1;
            if (state != ST_WAIT_FETCH) break;
            bad++;
        end
        check("timeout.wait_cycles", bad, 16);
        check("timeout.state", state, ST_TRAP);
        check("timeout.cause", trap_cause, 3'd5);
`else
        bad = 0;
        for (int c = 0; c < 1000; c++) begin
            @(posedge clk);
            #1;
            if (state !== ST_WAIT_FETCH || mem_req !== 1'b0) bad++;
        end
        check("no_timeout.wait_1000", bad, 0);
        check("no_timeout.cause", trap_cause, 3'd0);
`endif

        // Randomized instruction stream with spurious mem_ready outside wait states
        do_reset();
        run = 1'b1;
        noise_en = 1'b1;
        pc_m = 32'h0;
        instr_m = 32'h0;
        for (int i = 0; i < 60; i++) begin
            int unsigned k;
            k = $urandom_range(0, 99);
            ri = mk_in(0,0,0,0,0,0, int'($urandom_range(0, 4)), int'($urandom_range(0, 4)),
                       $urandom & 32'h0000_0FFC, pc_m + 32'h4, $urandom);
            if (k < 40) begin
                ri.ea[1:0] = 2'($urandom_range(0, 3));
            end else if (k < 60) begin
                ri.ld = 1'b1;
            end else if (k < 80) begin
                ri.st = 1'b1;
            end else begin
                case (k % 5)
                    0: ri.halt = 1'b1;
                    1: ri.derr = 1'b1;
                    2: ri.ferr = 1'b1;
                    3: begin ri.ld = 1'b1; ri.dmerr = 1'b1; end
                    default: begin ri.st = 1'b1; ri.ea[1:0] = 2'($urandom_range(1, 3)); end
                endcase
            end
            if ($urandom_range(0, 3) == 0) ri.npc = $urandom & 32'h0000_0FFC;
            e = model(ri, pc_m, instr_m, 0);
            exec(ri, r);
            cmp_res($sformatf("rand%0d", i), r, e);
            if (e.st == ST_HALT || e.st == ST_TRAP) begin
                do_reset();
                run = 1'b1;
                pc_m = 32'h0;
                instr_m = 32'h0;
            end else begin
                pc_m = e.pc;
                instr_m = e.instr;
            end
        end
        noise_en = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
